// File: rtl/button_event_ctrl.sv
// Push-button event controller: 2-flop sync, per-bit debounce, edge capture, masked level irq.
// Latency: in_port -> debounced level after 2 + period cycles; readdata 1 cycle after address; irq combinational from registers.
// Backpressure: none; Avalon-MM slave with zero wait states, writes take effect at the next clock edge.
//
// Ports:
//   clk, reset_n            clock and synchronous active-low reset
//   address, chipselect,    register select, slave select, active-low write strobe,
//   write_n, writedata      and write data (DATA=0 RO, MASK=1 RW, PERIOD=2 RW, EDGE=3 W1C)
//   readdata                registered read data, zero-extended to 32 bits
//   in_port                 raw asynchronous button levels
//   irq                     level interrupt, OR of masked captured edges
module button_event_ctrl #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 20,
  parameter int DB_DEFAULT = 50000,
  parameter int EDGE_MODE  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  typedef enum logic {STABLE = 1'b0, COUNTING = 1'b1} db_state_t;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] db_next;
  db_state_t        state      [WIDTH];
  db_state_t        state_next [WIDTH];
  logic [CNT_W-1:0] cnt        [WIDTH];
  logic [CNT_W-1:0] cnt_next   [WIDTH];
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_eff;
  logic [CNT_W-1:0] limit;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             wr_mask;
  logic             wr_period;
  logic             wr_edge;
  logic             unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_mask   = wr_en & (address == 2'd1);
  assign wr_period = wr_en & (address == 2'd2);
  assign wr_edge   = wr_en & (address == 2'd3);
  assign edge_clr  = wr_edge ? writedata[WIDTH-1:0] : '0;

  // Only the low register-width bits of writedata are meaningful.
  assign unused_wdata = ^writedata;

  // A programmed period of zero behaves as one cycle.
  assign period_eff = (period == '0) ? CNT_W'(1) : period;
  assign limit      = period_eff - CNT_W'(1);

  // Debounce FSM, one instance per bit. cnt holds the number of consecutive
  // differing samples seen so far; it never exceeds period-1.
  always_comb begin
    db_next = db;
    for (int i = 0; i < WIDTH; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      if (wr_period) begin
        // New period: restart every count from scratch, keep current levels.
        state_next[i] = STABLE;
        cnt_next[i]   = '0;
      end else begin
        case (state[i])
          STABLE: begin
            if (sync_q[i] != db[i]) begin
              if (limit == '0) begin
                // One-cycle period: the first differing sample is enough.
                db_next[i] = ~db[i];
                cnt_next[i] = '0;
              end else begin
                state_next[i] = COUNTING;
                cnt_next[i]   = CNT_W'(1);
              end
            end else begin
              cnt_next[i] = '0;
            end
          end
          COUNTING: begin
            if (sync_q[i] == db[i]) begin
              state_next[i] = STABLE;
              cnt_next[i]   = '0;
            end else if (cnt[i] >= limit) begin
              db_next[i]    = ~db[i];
              state_next[i] = STABLE;
              cnt_next[i]   = '0;
            end else begin
              cnt_next[i] = cnt[i] + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    case (EDGE_MODE)
      1:       edge_det = ~db & db_q;
      2:       edge_det = db ^ db_q;
      default: edge_det = db & ~db_q;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = db;
      2'd1:    rd_mux[WIDTH-1:0] = mask;
      2'd2:    rd_mux[CNT_W-1:0] = period;
      default: rd_mux[WIDTH-1:0] = edge_cap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
      db        <= '0;
      db_q      <= '0;
      edge_cap  <= '0;
      mask      <= '0;
      period    <= CNT_W'(DB_DEFAULT);
      readdata  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync_meta <= in_port;
      sync_q    <= sync_meta;
      db        <= db_next;
      db_q      <= db;
      // A new edge in the same cycle as its W1C survives the clear.
      edge_cap  <= (edge_cap & ~edge_clr) | edge_det;
      if (wr_mask) begin
        mask <= writedata[WIDTH-1:0];
      end
      if (wr_period) begin
        period <= writedata[CNT_W-1:0];
      end
      readdata <= rd_mux;
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
    end
  end

  assign irq = |(edge_cap & mask);

endmodule

// File: tb/tb_button_event_ctrl.sv
module tb_button_event_ctrl;
  localparam int W  = 4;
  localparam int CW = 20;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      address;
  logic            chipselect;
  logic            write_n;
  logic [31:0]     writedata;
  logic [W-1:0]    in_port;
  logic [2:0][31:0] rdata;
  logic [2:0]      irq_w;

  always #5 clk = ~clk;

  // One instance per edge mode (0 rise, 1 fall, 2 both), all on the same bus.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    button_event_ctrl #(
      .WIDTH(W), .CNT_W(CW), .DB_DEFAULT(50000), .EDGE_MODE(g)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rdata[g]),
      .in_port(in_port), .irq(irq_w[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  // Behavioural reference: sync delay line, per-bit run length of differing
  // samples, debounced level flips once the run reaches the period.
  logic [W-1:0]  m_s1, m_s2, m_db, m_dbq, m_mask;
  logic [W-1:0]  m_edge [3];
  logic [CW-1:0] m_period;
  int            m_run  [W];
  logic [31:0]   m_rd   [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycle();
    logic [W-1:0]  n_s1, n_s2, n_db, n_dbq, n_mask, clr, rise, fall;
    logic [W-1:0]  n_edge [3];
    logic [CW-1:0] n_period;
    int            n_run  [W];
    logic [31:0]   n_rd   [3];
    int            p;
    bit            wr;
    if (!reset_n) begin
      n_s1 = '0; n_s2 = '0; n_db = '0; n_dbq = '0; n_mask = '0;
      n_period = CW'(50000);
      for (int m = 0; m < 3; m++) begin n_edge[m] = '0; n_rd[m] = '0; end
      for (int i = 0; i < W; i++) n_run[i] = 0;
    end else begin
      wr = chipselect && !write_n;
      p  = (m_period == 0) ? 1 : int'(m_period);
      n_s1 = in_port;
      n_s2 = m_s1;
      n_db = m_db;
      for (int i = 0; i < W; i++) begin
        if (wr && address == 2'd2)   n_run[i] = 0;
        else if (m_s2[i] == m_db[i]) n_run[i] = 0;
        else if (m_run[i] + 1 >= p) begin n_db[i] = ~m_db[i]; n_run[i] = 0; end
        else                         n_run[i] = m_run[i] + 1;
      end
      n_dbq = m_db;
      rise  = m_db & ~m_dbq;
      fall  = ~m_db & m_dbq;
      clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      n_edge[0] = (m_edge[0] & ~clr) | rise;
      n_edge[1] = (m_edge[1] & ~clr) | fall;
      n_edge[2] = (m_edge[2] & ~clr) | rise | fall;
      n_mask   = (wr && address == 2'd1) ? writedata[W-1:0] : m_mask;
      n_period = (wr && address == 2'd2) ? writedata[CW-1:0] : m_period;
      for (int m = 0; m < 3; m++) begin
        case (address)
          2'd0:    n_rd[m] = 32'(m_db);
          2'd1:    n_rd[m] = 32'(m_mask);
          2'd2:    n_rd[m] = 32'(m_period);
          default: n_rd[m] = 32'(m_edge[m]);
        endcase
      end
    end
    @(posedge clk);
    m_s1 = n_s1; m_s2 = n_s2; m_db = n_db; m_dbq = n_dbq; m_mask = n_mask; m_period = n_period;
    for (int m = 0; m < 3; m++) begin m_edge[m] = n_edge[m]; m_rd[m] = n_rd[m]; end
    for (int i = 0; i < W; i++) m_run[i] = n_run[i];
    #1;
    for (int m = 0; m < 3; m++) begin
      check($sformatf("model_rd_m%0d", m), rdata[m], m_rd[m]);
      check($sformatf("model_irq_m%0d", m), 32'(irq_w[m]), 32'(|(m_edge[m] & m_mask)));
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, input int m, output logic [31:0] v);
    address = a;
    cycle();
    v = rdata[m];
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  initial begin
    reg_vec_t    tbl [6];
    logic [31:0] v;
    int          trans;
    logic        prev;
    int          r;

    tbl[0] = '{2'd1, 32'hFFFF_FFF5, 32'h0000_0005};
    tbl[1] = '{2'd1, 32'h0000_000A, 32'h0000_000A};
    tbl[2] = '{2'd2, 32'hFFF0_0003, 32'h0000_0003};
    tbl[3] = '{2'd2, 32'h000F_FFFF, 32'h000F_FFFF};
    tbl[4] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[5] = '{2'd3, 32'h0000_000F, 32'h0000_0000};

    // Reset with buttons held
    reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0;
    run(3);
    check("t1_rst_readdata", rdata[0], 32'h0);
    check("t1_rst_irq", 32'(irq_w[0]), 32'h0);
    reset_n = 1'b1;
    address = 2'd2;
    cycle();
    check("t1_period_default", rdata[0], 32'd50000);
    address = 2'd0;
    run(5);
    check("t1_data_held_low", rdata[0], 32'h0);
    in_port = 4'h0;
    run(4);

    // Register access table
    for (int k = 0; k < 6; k++) begin
      bus_wr(tbl[k].addr, tbl[k].wdata);
      bus_rd(tbl[k].addr, 0, v);
      check($sformatf("tbl_%0d", k), v, tbl[k].exp);
    end
    bus_wr(2'd1, 32'h0);
    bus_wr(2'd2, 32'd8);

    // Debounce latency with period 8
    address = 2'd0;
    in_port = 4'b0001;
    for (int k = 1; k <= 11; k++) begin
      cycle();
      if (k == 10) check("t2_data_before", rdata[0], 32'h0);
      if (k == 11) check("t2_data_after", rdata[0], 32'h1);
    end
    in_port = 4'b0101;
    run(5);
    in_port = 4'b0001;
    run(15);
    check("t2_pulse_rejected", rdata[0], 32'h1);
    bus_rd(2'd3, 0, v);
    check("t2_edge", v, 32'h1);
    bus_wr(2'd3, 32'hF);

    // Bouncing bit 1
    address = 2'd0;
    cycle();
    prev  = rdata[0][1];
    trans = 0;
    for (int k = 0; k < 60; k++) begin
      if (k < 40 && k % 3 == 0) in_port[1] = ~in_port[1];
      if (k == 40) in_port[1] = 1'b1;
      cycle();
      if (rdata[0][1] != prev) begin trans++; prev = rdata[0][1]; end
    end
    check("t3_transitions", 32'(trans), 32'd1);
    bus_rd(2'd3, 0, v);
    check("t3_edge", v, 32'h2);
    bus_wr(2'd3, 32'hF);

    // irq masking and W1C
    in_port = 4'b0000;
    run(15);
    bus_wr(2'd3, 32'hF);
    bus_wr(2'd1, 32'h2);
    in_port = 4'b0110;
    run(15);
    bus_rd(2'd3, 0, v);
    check("t4_edge", v, 32'h6);
    check("t4_irq_set", 32'(irq_w[0]), 32'h1);
    bus_wr(2'd3, 32'h2);
    check("t4_irq_cleared", 32'(irq_w[0]), 32'h0);
    bus_rd(2'd3, 0, v);
    check("t4_edge_after_w1c", v, 32'h4);
    bus_wr(2'd1, 32'hF);
    check("t4_irq_mask_all", 32'(irq_w[0]), 32'h1);

    // Set and clear in the same cycle
    in_port = 4'b1110;
    run(10);
    bus_wr(2'd3, 32'h8);
    bus_rd(2'd3, 0, v);
    check("t5_set_wins", v, 32'hC);

    // Period write mid-count restarts the count
    address = 2'd0;
    in_port = 4'b0110;
    run(5);
    bus_wr(2'd2, 32'd6);
    address = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      if (k == 6) check("t5_restart_before", rdata[0], 32'hE);
      if (k == 7) check("t5_restart_after", rdata[0], 32'h6);
    end

    // Period zero acts as one cycle
    bus_wr(2'd2, 32'h0);
    bus_rd(2'd2, 0, v);
    check("t6_period_zero", v, 32'h0);
    bus_wr(2'd3, 32'hF);
    address = 2'd0;
    in_port = 4'b0111;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      if (k == 3) check("t6_data_before", rdata[2], 32'h6);
      if (k == 4) check("t6_data_after", rdata[2], 32'h7);
    end
    run(2);
    bus_rd(2'd3, 2, v);
    check("t6_capture_press", v, 32'h1);
    bus_wr(2'd3, 32'hF);
    in_port = 4'b0110;
    run(6);
    bus_rd(2'd3, 2, v);
    check("t6_capture_release", v, 32'h1);
    check("t6_rise_mode_no_capture", rdata[0], 32'h0);
    check("t6_fall_mode_capture", rdata[1], 32'h1);

    // Randomised traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) in_port = W'($urandom);
      else if (r < 6) in_port[$urandom_range(0, W-1)] = ~in_port[$urandom_range(0, W-1)];
      address    = 2'($urandom);
      chipselect = ($urandom_range(0, 9) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      writedata  = ($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 6));
      reset_n    = ($urandom_range(0, 499) != 0);
      cycle();
    end
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
